// File: rtl/mod_pkg.sv
// Shared modulation definitions for the mapper/demapper bit buffers.
// Provides Mod_Order codes, the serializer FSM state type and the bits-per-symbol helper.
package mod_pkg;

    localparam int unsigned QM_W = 3;

    localparam logic [1:0] MOD_BPSK  = 2'd0;
    localparam logic [1:0] MOD_QPSK  = 2'd1;
    localparam logic [1:0] MOD_16QAM = 2'd2;
    localparam logic [1:0] MOD_64QAM = 2'd3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } ser_state_t;

    // Bits per symbol (Qm) for a Mod_Order code
    function automatic logic [QM_W-1:0] qm_of(input logic [1:0] order);
        case (order)
            MOD_BPSK:  qm_of = QM_W'(1);
            MOD_QPSK:  qm_of = QM_W'(2);
            MOD_16QAM: qm_of = QM_W'(4);
            MOD_64QAM: qm_of = QM_W'(6);
        endcase
    endfunction

endpackage

// File: rtl/mod_bit_serializer.sv
// Receive-side bit serializer: takes one hard-decision bit group per symbol and
// streams it LSB first, one bit per cycle, with ready/valid on both sides.
// Optional frame-length tracking (Frame_Len / Ser_Last) is enabled by SER_LAST_EN.
module mod_bit_serializer
    import mod_pkg::*;
#(
    parameter int unsigned MAX_QM = 6
)
(
    input  logic              CLK,
    input  logic              RST,
    input  logic [1:0]        Mod_Order,
    input  logic [MAX_QM-1:0] Demod_In,
    input  logic              Demod_Valid,
    output logic              Demod_Ready,
    output logic              Ser_Out,
    output logic              Ser_Valid,
    input  logic              Ser_Ready,
`ifdef SER_LAST_EN
    input  logic [15:0]       Frame_Len,
    output logic              Ser_Last,
`endif
    output logic              Busy
);

    localparam int unsigned CNT_W = $clog2(MAX_QM + 1);
    localparam int unsigned REM_W = 16;

    ser_state_t        state, state_nxt;
    logic [MAX_QM-1:0] shreg, shreg_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [REM_W-1:0]  rem, rem_nxt;

    logic accept;
    logic bit_hs;
    logic frame_end;
    logic word_done;

    // Handshake decode; a word ends on its last bit or on the frame's last bit
    always_comb begin
        bit_hs    = (state == ST_SHIFT) && Ser_Ready;
`ifdef SER_LAST_EN
        frame_end = bit_hs && (rem == REM_W'(1));
`else
        frame_end = 1'b0;
`endif
        word_done   = (bit_hs && (cnt == CNT_W'(1))) || frame_end;
        Demod_Ready = (state == ST_IDLE) || word_done;
        accept      = Demod_Valid && Demod_Ready;
    end

    // Next-state, shift register, bit counter and frame counter
    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        cnt_nxt   = cnt;
        rem_nxt   = rem;

        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = ST_SHIFT;
                    shreg_nxt = Demod_In;
                    cnt_nxt   = CNT_W'(qm_of(Mod_Order));
                end
            end
            ST_SHIFT: begin
                if (word_done) begin
                    if (accept) begin
                        shreg_nxt = Demod_In;
                        cnt_nxt   = CNT_W'(qm_of(Mod_Order));
                    end else begin
                        state_nxt = ST_IDLE;
                        shreg_nxt = '0;
                        cnt_nxt   = '0;
                    end
                end else if (bit_hs) begin
                    shreg_nxt = shreg >> 1;
                    cnt_nxt   = cnt - CNT_W'(1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

`ifdef SER_LAST_EN
        if (bit_hs && (rem != '0)) begin
            rem_nxt = rem - REM_W'(1);
        end
        if (accept && ((rem == '0) || frame_end)) begin
            rem_nxt = (Frame_Len == '0) ? REM_W'(1) : Frame_Len;
        end
`endif
    end

    // State and datapath registers
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= ST_IDLE;
            shreg <= '0;
            cnt   <= '0;
            rem   <= '0;
        end else begin
            state <= state_nxt;
            shreg <= shreg_nxt;
            cnt   <= cnt_nxt;
            rem   <= rem_nxt;
        end
    end

    // Outputs decode registers only; shreg is cleared whenever IDLE so Ser_Out is 0 there
    assign Ser_Valid = (state == ST_SHIFT);
    assign Busy      = (state == ST_SHIFT);
    assign Ser_Out   = shreg[0];
`ifdef SER_LAST_EN
    assign Ser_Last  = (state == ST_SHIFT) && (rem == REM_W'(1));
`endif

endmodule

// File: tb/tb_mod_bit_serializer.sv
// Self-checking bench for mod_bit_serializer (SER_LAST_EN adds frame-length cases).
// A queue of pending serial bits models the expected output stream.
module tb_mod_bit_serializer;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [1:0] mod_order   = 2'd0;
    logic [5:0] demod_in    = 6'd0;
    logic       demod_valid = 1'b0;
    logic       demod_ready;
    logic       ser_out;
    logic       ser_valid;
    logic       ser_ready   = 1'b0;
    logic       busy;
`ifdef SER_LAST_EN
    logic [15:0] frame_len  = 16'hFFFF;
    logic        ser_last;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    bit q[$];
    bit outlog[$];
    int rem = 0;

    always #5 CLK = ~CLK;

    mod_bit_serializer dut (
        .CLK         (CLK),
        .RST         (RST),
        .Mod_Order   (mod_order),
        .Demod_In    (demod_in),
        .Demod_Valid (demod_valid),
        .Demod_Ready (demod_ready),
        .Ser_Out     (ser_out),
        .Ser_Valid   (ser_valid),
        .Ser_Ready   (ser_ready),
`ifdef SER_LAST_EN
        .Frame_Len   (frame_len),
        .Ser_Last    (ser_last),
`endif
        .Busy        (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int qm(input logic [1:0] o);
        return (o == 2'd3) ? 6 : (1 << o);
    endfunction

    // Compare the logged serial bits against a vector written in emission order (MSB = first bit)
    task automatic chk_log(input string tag, input logic [15:0] expv, input int n);
        logic [15:0] got;
        chk({tag, "_len"}, outlog.size(), n);
        got = '0;
        for (int i = 0; i < n && i < outlog.size(); i++) got[n-1-i] = outlog[i];
        chk(tag, got, expv);
        outlog.delete();
    endtask

    // One clock: drive inputs, check outputs at the falling edge, advance the model at the rising edge
    task automatic cycle(input logic dv, input logic [1:0] mo, input logic [5:0] din, input logic sr);
        bit exp_valid, exp_ready, acc, hs;
        demod_valid = dv;
        mod_order   = mo;
        demod_in    = din;
        ser_ready   = sr;
        @(negedge CLK);
        exp_valid = (q.size() != 0);
        exp_ready = (q.size() == 0) || (sr && ((q.size() == 1) || (rem == 1)));
        chk("ser_valid", ser_valid, exp_valid);
        chk("ser_out", ser_out, exp_valid ? q[0] : 1'b0);
        chk("busy", busy, exp_valid);
        chk("demod_ready", demod_ready, exp_ready);
`ifdef SER_LAST_EN
        chk("ser_last", ser_last, exp_valid && (rem == 1));
`endif
        acc = dv && exp_ready;
        hs  = exp_valid && sr;
        @(posedge CLK);
        if (hs) begin
            outlog.push_back(q.pop_front());
`ifdef SER_LAST_EN
            rem--;
            if (rem == 0) q.delete();
`endif
        end
        if (acc) begin
`ifdef SER_LAST_EN
            if (rem == 0) rem = (frame_len == 16'd0) ? 1 : int'(frame_len);
`endif
            for (int i = 0; i < qm(mo); i++) q.push_back(din[i]);
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 2'd0, 6'd0, 1'b1);
    endtask

    initial begin
        // Reset values while RST is held
        #3;
        chk("rst_ser_valid", ser_valid, 1'b0);
        chk("rst_ser_out", ser_out, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_demod_ready", demod_ready, 1'b1);
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        idle(5);

        // QPSK 2'b10: bits 0 then 1, ready during the second bit, busy drops afterwards
        outlog.delete();
        cycle(1'b1, 2'd1, 6'b000010, 1'b1);
        idle(3);
        chk_log("qpsk_bits", 16'b01, 2);

        // 64QAM back-to-back with zero bubble
        cycle(1'b1, 2'd3, 6'b101101, 1'b1);
        idle(5);
        cycle(1'b1, 2'd3, 6'b010011, 1'b1);
        idle(7);
        chk_log("qam64_b2b", 16'b101101110010, 12);

        // 16QAM 4'b0110 with a 3-cycle stall after the first bit
        cycle(1'b1, 2'd2, 6'b000110, 1'b1);
        cycle(1'b0, 2'd0, 6'd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 2'd0, 6'd0, 1'b0);
            chk("stall_hold", ser_out, 1'b1);
        end
        idle(4);
        chk_log("qam16_stall", 16'b0110, 4);

        // Mod_Order changes mid-word only affect the next word
        cycle(1'b1, 2'd3, 6'b100110, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b0, 2'd0, 6'd0, 1'b1);
        cycle(1'b1, 2'd0, 6'b111111, 1'b1);
        idle(3);
        chk_log("order_change", 16'b0110011, 7);

        // Asynchronous reset mid-word discards the pending bits
        cycle(1'b1, 2'd3, 6'b111111, 1'b1);
        cycle(1'b0, 2'd0, 6'd0, 1'b1);
        cycle(1'b0, 2'd0, 6'd0, 1'b1);
        #2;
        RST = 1'b0;
        #1;
        chk("midrst_ser_valid", ser_valid, 1'b0);
        chk("midrst_ser_out", ser_out, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_demod_ready", demod_ready, 1'b1);
        q.delete();
        rem = 0;
        @(posedge CLK);
        #1;
        RST = 1'b1;
        idle(4);
        outlog.delete();

`ifdef SER_LAST_EN
        // Frame of 5 bits over QPSK words 11, 01, 10: last bit of the third word dropped
        frame_len = 16'd5;
        cycle(1'b1, 2'd1, 6'b000011, 1'b1);
        cycle(1'b0, 2'd0, 6'd0, 1'b1);
        cycle(1'b1, 2'd1, 6'b000001, 1'b1);
        cycle(1'b0, 2'd0, 6'd0, 1'b1);
        cycle(1'b1, 2'd1, 6'b000010, 1'b1);
        chk("frame_last_bit", ser_last, 1'b1);
        cycle(1'b0, 2'd0, 6'd0, 1'b1);
        idle(2);
        chk_log("frame_bits", 16'b11100, 5);
        chk("frame_rem_clear", rem, 0);
        cycle(1'b1, 2'd1, 6'b000011, 1'b1);
        chk("frame_reload", rem, 5);
        idle(3);
        outlog.delete();
        frame_len = 16'd7;
`endif

        // Randomized traffic with random backpressure and garbage upper bits
        for (int i = 0; i < 400; i++) begin
            cycle(1'(($urandom % 4) != 0), 2'($urandom), 6'($urandom), 1'(($urandom % 4) != 0));
        end
        idle(10);
        chk("drain_empty", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
